step_counter: RTL
=================

// Module: step_counter
// PURPOSE
//  Registered, parametrised successor to the combinational INC/DEC datapath components.
//  Holds a count that steps up or down by STEP each enabled cycle, within the
//  runtime range 0..lim, with load, direction, terminal-count and overflow pulse.
//  Used as the loop/index counter component emitted by the HLS netlist generator.
// PARAMETERS
//  DATAWIDTH  32  width of din, lim and cnt
//  STEP       1   step magnitude; unsigned, legal range 1..2**DATAWIDTH-1
// PORTS
//  clk  input   1          rising-edge clock; the block's only clock
//  rst  input   1          synchronous, active-low reset
//  en   input   1          count enable, one step per cycle
//  ld   input   1          load din into cnt
//  dir  input   1          1 = count up, 0 = count down
//  din  input   DATAWIDTH  load value
//  lim  input   DATAWIDTH  inclusive upper bound of the count range
//  cnt  output  DATAWIDTH  registered count
//  tc   output  1          terminal count: (dir ? cnt==lim : cnt==0); combinational from cnt/dir/lim
//  ovf  output  1          registered 1-cycle pulse: the last step crossed a range bound
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): cnt<=0, ovf<=0. Reset overrides ld and en; mid-count reset discards count.
//  - Priority each posedge: rst > ld > en > hold.
//  - ld: cnt <= (din>lim) ? lim : din; ovf<=0. en ignored in that cycle.
//  - en & !ld: step computed at DATAWIDTH+1 bits, no truncation before compare.
//    up:   s = cnt+STEP; if s<=lim: cnt<=s, ovf<=0; else wrap: w = s-(lim+1), cnt <= (w>lim)?0:w, ovf<=1.
//    down: if cnt>=STEP: cnt<=cnt-STEP, ovf<=0; else wrap: w = cnt+(lim+1)-STEP, cnt <= (w>lim)?lim:w, ovf<=1.
//  - cnt>lim at step time (lim lowered at runtime): the step yields cnt<=0 (up) or cnt<=lim (down), ovf<=1.
//  - en=0 & ld=0: cnt holds, ovf<=0. ovf is never high for two cycles unless a bound is crossed in each.
//  - lim==0: range is {0}; every enabled step gives cnt=0, ovf=1.
//  - Latency: cnt/ovf update 1 cycle after the sampled ld/en; tc follows cnt/dir/lim with no delay.
//  - dir may change on any cycle; it applies to the step taken at that edge.
// CONFIGURATION
//  STEP_COUNTER_SAT_EN
//   undefined: wrap-around arithmetic as above.
//   defined:   saturating; up-cross gives cnt<=lim, down-cross gives cnt<=0, ovf<=1 on every
//              step that would cross, including repeated steps while held at the bound.
//              Runtime lim-lowered case: cnt<=lim, ovf<=1 in both directions.
//   Port list and reset behaviour are identical in both builds.
// TESTING  (DATAWIDTH=8, STEP=3, lim=10 unless stated)
//  1 rst=0 for 10 cycles, dir=1 -> cnt=0, ovf=0, tc=0; release rst, en=0 -> cnt holds at 0.
//  2 en=1 dir=1 from 0 -> cnt 3,6,9,1 with ovf=1 only on 9->1 (SAT_EN: 9->10->10, ovf=1 each 10 step).
//  3 ld din=1, then en=1 dir=0 -> cnt 9 with ovf=1, then 6,3,0 with tc=1 at 0 (SAT_EN: 1->0, ovf=1).
//  4 ld=1 din=200 with en=1 same cycle -> cnt=10, ovf=0, tc=1; next en step up -> cnt=2, ovf=1.
//  5 lim=255, ld din=254, en up -> cnt=1, ovf=1 (no 8-bit truncation; SAT_EN: cnt=255).
//  6 cnt=9, lim driven to 5, en up -> cnt=0, ovf=1; rst=0 asserted with en=1 mid-count -> cnt=0 next edge.
//  Bench: random en/ld/dir/din/lim against a DATAWIDTH+1-bit reference model via error_monitor.

Source files
------------

// File: rtl/step_counter.sv
// rtl/step_counter.sv - registered up/down step counter bounded to 0..lim, optional saturation via STEP_COUNTER_SAT_EN
module step_counter #(
    parameter int          DATAWIDTH = 32,
    parameter int unsigned STEP      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 ld,
    input  logic                 dir,
    input  logic [DATAWIDTH-1:0] din,
    input  logic [DATAWIDTH-1:0] lim,
    output logic [DATAWIDTH-1:0] cnt,
    output logic                 tc,
    output logic                 ovf
);

    // One extra bit so cnt+STEP and cnt+lim+1 never truncate before comparison.
    localparam logic [DATAWIDTH:0] STEP_X = (DATAWIDTH+1)'(STEP);

    logic [DATAWIDTH:0]   cnt_x;
    logic [DATAWIDTH:0]   lim_x;
    logic [DATAWIDTH:0]   sum_up;
    logic [DATAWIDTH-1:0] cnt_next;
    logic                 ovf_next;
`ifndef STEP_COUNTER_SAT_EN
    logic [DATAWIDTH:0]   lim_p1;
    logic [DATAWIDTH:0]   wrap_up;
    logic [DATAWIDTH:0]   wrap_dn;
`endif

    assign cnt_x  = {1'b0, cnt};
    assign lim_x  = {1'b0, lim};
    assign sum_up = cnt_x + STEP_X;

`ifndef STEP_COUNTER_SAT_EN
    // Wrap targets: the overshoot re-enters the range from the opposite bound.
    // A negative down-wrap becomes a huge unsigned value and therefore clamps to lim.
    assign lim_p1  = lim_x + 1'b1;
    assign wrap_up = sum_up - lim_p1;
    assign wrap_dn = cnt_x + lim_p1 - STEP_X;
`endif

    // Next count and overflow pulse; priority ld > en > hold (reset handled in the register).
    always_comb begin
        cnt_next = cnt;
        ovf_next = 1'b0;
        if (ld) begin
            cnt_next = (din > lim) ? lim : din;
        end else if (en) begin
            if (cnt > lim) begin
                // lim was lowered below the current count at runtime
                ovf_next = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                cnt_next = lim;
`else
                cnt_next = dir ? '0 : lim;
`endif
            end else if (dir) begin
                if (sum_up <= lim_x) begin
                    cnt_next = sum_up[DATAWIDTH-1:0];
                end else begin
                    ovf_next = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                    cnt_next = lim;
`else
                    cnt_next = (wrap_up > lim_x) ? '0 : wrap_up[DATAWIDTH-1:0];
`endif
                end
            end else begin
                if (cnt_x >= STEP_X) begin
                    cnt_next = cnt - STEP_X[DATAWIDTH-1:0];
                end else begin
                    ovf_next = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                    cnt_next = '0;
`else
                    cnt_next = (wrap_dn > lim_x) ? lim : wrap_dn[DATAWIDTH-1:0];
`endif
                end
            end
        end
    end

    // Count and overflow registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

    // Terminal count follows cnt/dir/lim without delay.
    always_comb begin
        tc = dir ? (cnt == lim) : (cnt == '0);
    end

endmodule
